// File: rtl/instruction_decode_types.sv
// Shared decode types: load/store variants, memory-stage FSM encoding and
// size/alignment helpers used by the memory stage.
package instruction_decode_types;

    typedef enum logic [2:0] {
        LS_B  = 3'd0,
        LS_H  = 3'd1,
        LS_W  = 3'd2,
        LS_D  = 3'd3,
        LS_BU = 3'd4,
        LS_HU = 3'd5,
        LS_WU = 3'd6
    } load_store_variant_e;

    // Plain-vector state encoding keeps the FSM compatible with older flows
    typedef logic [1:0] mem_fsm_e;
    localparam mem_fsm_e ST_IDLE     = 2'd0;
    localparam mem_fsm_e ST_MEM_REQ  = 2'd1;
    localparam mem_fsm_e ST_MEM_WAIT = 2'd2;
    localparam mem_fsm_e ST_HOLD     = 2'd3;

    // Byte-enable pattern for an access at byte offset 0
    function automatic logic [7:0] size_mask(input load_store_variant_e variant);
        case (variant)
            LS_B, LS_BU: size_mask = 8'h01;
            LS_H, LS_HU: size_mask = 8'h03;
            LS_W, LS_WU: size_mask = 8'h0F;
            default:     size_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_mask(input load_store_variant_e variant);
        case (variant)
            LS_B, LS_BU: align_mask = 3'b000;
            LS_H, LS_HU: align_mask = 3'b001;
            LS_W, LS_WU: align_mask = 3'b011;
            default:     align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Picks the addressed lane out of a returned doubleword and sign- or
// zero-extends it according to the load variant.
module load_align_extend
    import instruction_decode_types::*;
(
    input  logic [63:0]         rdata,
    input  logic [2:0]          offset,
    input  load_store_variant_e variant,
    output logic [63:0]         result
);

    logic [63:0] lane;

    assign lane = rdata >> {offset, 3'b000};

    // Extend the low bytes of the shifted lane to the full register width
    always_comb begin
        case (variant)
            LS_B:    result = {{56{lane[7]}},  lane[7:0]};
            LS_H:    result = {{48{lane[15]}}, lane[15:0]};
            LS_W:    result = {{32{lane[31]}}, lane[31:0]};
            LS_BU:   result = {56'd0, lane[7:0]};
            LS_HU:   result = {48'd0, lane[15:0]};
            LS_WU:   result = {32'd0, lane[31:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid doubleword port,
// aligns load data, and presents a registered writeback bundle. Upstream is
// stalled while an access is outstanding; a finished access that meets a
// downstream stall is parked in a one-entry hold buffer.
module memory_access
    import instruction_decode_types::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [XLEN-1:0]     in_result,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [4:0]          in_rd,
    input  logic                in_write_to_rd,
    input  logic                in_is_mem,
    input  logic                in_is_write,
    input  load_store_variant_e in_ls_variant,
    input  logic                in_is_final,
    input  logic                stall_in,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [7:0]          dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_valid_q,
    output logic [4:0]          wb_rd_q,
    output logic [XLEN-1:0]     wb_data_q,
    output logic                wb_write_rd_q,
    output logic                wb_final_q,
    output logic                misaligned_q,
    output logic                dmem_timeout_q
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(MAX_WAIT)) sat_inc = v;
        else                       sat_inc = v + CNT_W'(1);
    endfunction

    mem_fsm_e            state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q;

    // Access captured at request start; execute may move on afterwards
    logic [XLEN-1:3]     addr_hi_r;
    logic [2:0]          off_r;
    load_store_variant_e var_r;
    logic                we_r;
    logic [7:0]          be_r;
    logic [XLEN-1:0]     wdata_r;
    logic [4:0]          rd_r;
    logic                wr_rd_r;
    logic                final_r;

    logic                hold_valid_q;
    logic [4:0]          hold_rd_q;
    logic [XLEN-1:0]     hold_data_q;
    logic                hold_write_q;
    logic                hold_final_q;

    logic [2:0]          in_off;
    logic                in_mis;
    logic                start;
    logic [7:0]          in_be;
    logic [XLEN-1:0]     in_wdata;
    logic                idle_store_done;
    logic                acc_done;
    logic                busy;
    logic [XLEN-1:0]     load_data;

    logic                cmp_valid;
    logic [4:0]          cmp_rd;
    logic [XLEN-1:0]     cmp_data;
    logic                cmp_write;
    logic                cmp_final;
    logic                cmp_mis;

    assign in_off   = in_result[2:0];
    assign in_mis   = (in_off & align_mask(in_ls_variant)) != 3'b000;
    assign start    = rst && (state_q == ST_IDLE) && !stall_in && in_valid && in_is_mem && !in_mis;
    assign in_be    = size_mask(in_ls_variant) << in_off;
    assign in_wdata = in_store_data << {in_off, 3'b000};

    assign dmem_req   = start || (state_q == ST_MEM_REQ);
    assign dmem_we    = start ? in_is_write : we_r;
    assign dmem_addr  = start ? {in_result[XLEN-1:3], 3'b000} : {addr_hi_r, 3'b000};
    assign dmem_be    = start ? in_be : be_r;
    assign dmem_wdata = start ? in_wdata : wdata_r;

    assign idle_store_done = start && dmem_gnt && in_is_write;
    assign acc_done = ((state_q == ST_MEM_REQ) && dmem_gnt && (we_r || dmem_rvalid))
                   || ((state_q == ST_MEM_WAIT) && dmem_rvalid);
    assign busy = (start && !idle_store_done)
               || (((state_q == ST_MEM_REQ) || (state_q == ST_MEM_WAIT)) && !acc_done);
    assign stall_out = stall_in || busy;

    load_align_extend u_align (
        .rdata   (dmem_rdata),
        .offset  (off_r),
        .variant (var_r),
        .result  (load_data)
    );

    // Bundle of whatever instruction finishes this cycle (outside HOLD)
    always_comb begin
        cmp_valid = 1'b0;
        cmp_rd    = in_rd;
        cmp_data  = in_result;
        cmp_write = 1'b0;
        cmp_final = in_is_final;
        cmp_mis   = 1'b0;
        if (acc_done) begin
            cmp_valid = 1'b1;
            cmp_rd    = rd_r;
            cmp_data  = load_data;
            cmp_write = wr_rd_r && !we_r;
            cmp_final = final_r;
        end else if (state_q == ST_IDLE) begin
            cmp_valid = in_valid && (!in_is_mem || in_mis || idle_store_done);
            cmp_write = in_write_to_rd && !(in_is_mem && (in_is_write || in_mis));
            cmp_mis   = in_valid && in_is_mem && in_mis;
        end
    end

    // Next-state selection for the access sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dmem_gnt) state_d = in_is_write ? ST_IDLE : ST_MEM_WAIT;
                    else          state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (acc_done)      state_d = stall_in ? ST_HOLD : ST_IDLE;
                else if (dmem_gnt) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (acc_done) state_d = stall_in ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!stall_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Wait-cycle counter and one-shot timeout pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q     <= '0;
            dmem_timeout_q <= 1'b0;
        end else begin
            dmem_timeout_q <= 1'b0;
            if (start) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_MEM_WAIT) begin
                wait_cnt_q     <= sat_inc(wait_cnt_q);
                dmem_timeout_q <= (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
            end
        end
    end

    // Capture the request and its writeback fields when the access starts
    always_ff @(posedge clk) begin
        if (start) begin
            addr_hi_r <= in_result[XLEN-1:3];
            off_r     <= in_off;
            var_r     <= in_ls_variant;
            we_r      <= in_is_write;
            be_r      <= in_be;
            wdata_r   <= in_wdata;
            rd_r      <= in_rd;
            wr_rd_r   <= in_write_to_rd;
            final_r   <= in_is_final;
        end
    end

    // Park a finished access while writeback is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
        end else if (acc_done && stall_in) begin
            hold_valid_q <= 1'b1;
            hold_rd_q    <= cmp_rd;
            hold_data_q  <= cmp_data;
            hold_write_q <= cmp_write;
            hold_final_q <= cmp_final;
        end else if ((state_q == ST_HOLD) && !stall_in) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Writeback bundle: frozen under stall, else loaded from hold or this cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_write_rd_q <= 1'b0;
            wb_final_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else if (!stall_in) begin
            if (state_q == ST_HOLD) begin
                wb_valid_q    <= hold_valid_q;
                wb_rd_q       <= hold_rd_q;
                wb_data_q     <= hold_data_q;
                wb_write_rd_q <= hold_write_q;
                wb_final_q    <= hold_final_q;
                misaligned_q  <= 1'b0;
            end else begin
                wb_valid_q    <= cmp_valid;
                wb_rd_q       <= cmp_rd;
                wb_data_q     <= cmp_data;
                wb_write_rd_q <= cmp_write;
                wb_final_q    <= cmp_final;
                misaligned_q  <= cmp_mis;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for the memory stage: directed scenarios followed by randomized
// accesses, each checked against a byte-level reference model.
module tb_memory_access;
    import instruction_decode_types::*;

    localparam int MAX_WAIT = 15;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [63:0]         in_result;
    logic [63:0]         in_store_data;
    logic [4:0]          in_rd;
    logic                in_write_to_rd;
    logic                in_is_mem;
    logic                in_is_write;
    load_store_variant_e in_ls_variant;
    logic                in_is_final;
    logic                stall_in;
    logic                stall_out;
    logic                dmem_req;
    logic                dmem_we;
    logic [63:0]         dmem_addr;
    logic [7:0]          dmem_be;
    logic [63:0]         dmem_wdata;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [63:0]         dmem_rdata;
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic [63:0]         wb_data_q;
    logic                wb_write_rd_q;
    logic                wb_final_q;
    logic                misaligned_q;
    logic                dmem_timeout_q;

    int n_tests = 0;
    int n_fail  = 0;

    memory_access #(.XLEN(64), .MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_result      (in_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_write_to_rd (in_write_to_rd),
        .in_is_mem      (in_is_mem),
        .in_is_write    (in_is_write),
        .in_ls_variant  (in_ls_variant),
        .in_is_final    (in_is_final),
        .stall_in       (stall_in),
        .stall_out      (stall_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid_q     (wb_valid_q),
        .wb_rd_q        (wb_rd_q),
        .wb_data_q      (wb_data_q),
        .wb_write_rd_q  (wb_write_rd_q),
        .wb_final_q     (wb_final_q),
        .misaligned_q   (misaligned_q),
        .dmem_timeout_q (dmem_timeout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input load_store_variant_e v);
        case (v)
            LS_B, LS_BU: size_of = 1;
            LS_H, LS_HU: size_of = 2;
            LS_W, LS_WU: size_of = 4;
            default:     size_of = 8;
        endcase
    endfunction

    function automatic logic is_sgn(input load_store_variant_e v);
        is_sgn = (v == LS_B) || (v == LS_H) || (v == LS_W);
    endfunction

    function automatic logic [7:0] model_be(input int off, input int sz);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < sz; i++) if (off + i < 8) b[off + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [63:0] model_wdata(input int off, input int sz, input logic [63:0] d);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < sz; i++) if (off + i < 8) w[8*(off+i) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    function automatic logic [63:0] model_load(input int off, input int sz, input logic sgn,
                                               input logic [63:0] r);
        logic [63:0] val;
        val = '0;
        for (int i = 0; i < sz; i++) if (off + i < 8) val[8*i +: 8] = r[8*(off+i) +: 8];
        if (sgn && val[8*sz-1]) for (int i = sz; i < 8; i++) val[8*i +: 8] = 8'hFF;
        return val;
    endfunction

    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // One instruction from execute plus the memory's response; called at posedge+1
    task automatic do_access(input logic mem, input logic wr, input load_store_variant_e v,
                             input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd,
                             input int gd, input int rdl, input logic [63:0] rdat,
                             output int stall_n, output int req_n,
                             output logic [7:0] be_o, output logic [63:0] wd_o);
        int sz, off, gc, to_n, exp_stall, exp_req, exp_to;
        logic mis, wtr, fin, accepted, fld_bad, st;
        logic [7:0] ebe;
        logic [63:0] ewd, emask, eld;
        sz    = size_of(v);
        off   = int'(addr[2:0]);
        mis   = mem && ((addr % 64'(sz)) != 64'd0);
        ebe   = model_be(off, sz);
        ewd   = model_wdata(off, sz, sdata);
        emask = be_to_mask(ebe);
        eld   = model_load(off, sz, is_sgn(v), rdat);
        wtr   = 1'($urandom_range(0, 1));
        fin   = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_is_mem = mem; in_is_write = wr; in_ls_variant = v;
        in_result = addr; in_store_data = sdata; in_rd = rd;
        in_write_to_rd = wtr; in_is_final = fin;
        stall_n = 0; req_n = 0; gc = -1; to_n = 0; accepted = 1'b0; fld_bad = 1'b0;
        be_o = '0; wd_o = '0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = {$urandom, $urandom};
            if (dmem_req) begin
                if (req_n == 0) begin be_o = dmem_be; wd_o = dmem_wdata; end
                if (dmem_addr !== {addr[63:3], 3'b000} || dmem_be !== ebe || dmem_we !== wr
                    || (wr && ((dmem_wdata & emask) !== (ewd & emask)))) fld_bad = 1'b1;
                if (req_n == gd) begin dmem_gnt = 1'b1; gc = c; end
                req_n++;
            end
            if (gc >= 0 && !wr && c == gc + 1 + rdl) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdat;
            end
            #1;
            st = stall_out;
            if (st) stall_n++;
            tick();
            if (dmem_timeout_q) to_n++;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (!st) begin
                accepted = 1'b1;
            end else begin
                in_result = {$urandom, $urandom}; in_store_data = {$urandom, $urandom};
                in_rd = 5'($urandom); in_is_write = 1'($urandom);
                in_ls_variant = load_store_variant_e'(3'($urandom_range(0, 6)));
                in_write_to_rd = 1'($urandom); in_is_final = 1'($urandom);
            end
        end
        in_valid = 1'b0; in_is_mem = 1'b0;
        exp_req   = (!mem || mis) ? 0 : gd + 1;
        exp_stall = (!mem || mis) ? 0 : (wr ? gd : gd + 1 + rdl);
        exp_to    = (mem && !mis && !wr && (rdl + 1) >= MAX_WAIT) ? 1 : 0;
        check("accepted", 64'(accepted), 64'(1));
        check("req_cycles", 64'(req_n), 64'(exp_req));
        check("stall_cycles", 64'(stall_n), 64'(exp_stall));
        check("timeout_pulses", 64'(to_n), 64'(exp_to));
        if (mem && !mis) check("dmem_fields", 64'(fld_bad), 64'(0));
        check("wb_valid", 64'(wb_valid_q), 64'(1));
        check("wb_rd", 64'(wb_rd_q), 64'(rd));
        check("wb_write_rd", 64'(wb_write_rd_q), 64'((mem && (wr || mis)) ? 1'b0 : wtr));
        check("wb_final", 64'(wb_final_q), 64'(fin));
        check("misaligned", 64'(misaligned_q), 64'(mis));
        if (!mem) check("wb_data_alu", wb_data_q, addr);
        if (mem && !mis && !wr) check("wb_data_load", wb_data_q, eld);
    endtask

    initial begin
        int st_n, rq_n, gd, rdl, vi;
        logic [7:0] be_o;
        logic [63:0] wd_o, addr;
        logic mem, wr;
        load_store_variant_e v;

        rst = 1'b0; in_valid = 1'b0; in_result = '0; in_store_data = '0; in_rd = '0;
        in_write_to_rd = 1'b0; in_is_mem = 1'b0; in_is_write = 1'b0; in_ls_variant = LS_D;
        in_is_final = 1'b0; stall_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 64'(wb_valid_q), 64'(0));
        check("rst_wb_data", wb_data_q, 64'd0);
        check("rst_wb_rd", 64'(wb_rd_q), 64'(0));
        check("rst_misaligned", 64'(misaligned_q), 64'(0));
        check("rst_timeout", 64'(dmem_timeout_q), 64'(0));
        check("rst_dmem_req", 64'(dmem_req), 64'(0));
        check("rst_stall_out", 64'(stall_out), 64'(0));
        rst = 1'b1;
        tick();

        // ALU pass-through
        do_access(1'b0, 1'b0, LS_D, 64'h1234, 64'd0, 5'd5, 0, 0, 64'd0, st_n, rq_n, be_o, wd_o);
        check("alu_data", wb_data_q, 64'h1234);
        tick();
        check("alu_bubble", 64'(wb_valid_q), 64'(0));

        // LB with sign extension and four stalled cycles
        do_access(1'b1, 1'b0, LS_B, 64'h1003, 64'd0, 5'd4, 0, 3, 64'h1122_3344_8055_6677,
                  st_n, rq_n, be_o, wd_o);
        check("lb_data", wb_data_q, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_stall", 64'(st_n), 64'(4));

        // SH to the top halfword, grant after two cycles
        do_access(1'b1, 1'b1, LS_H, 64'h2006, 64'hABCD, 5'd6, 2, 0, 64'd0, st_n, rq_n, be_o, wd_o);
        check("sh_be", 64'(be_o), 64'hC0);
        check("sh_wdata", 64'(wd_o[63:48]), 64'hABCD);
        check("sh_req_cycles", 64'(rq_n), 64'(3));

        // Misaligned LW
        do_access(1'b1, 1'b0, LS_W, 64'h1002, 64'd0, 5'd8, 0, 0, 64'd0, st_n, rq_n, be_o, wd_o);
        check("lw_mis_req", 64'(rq_n), 64'(0));

        // LD finishing under a three-cycle downstream stall
        do_access(1'b0, 1'b0, LS_D, 64'hBEEF, 64'd0, 5'd7, 0, 0, 64'd0, st_n, rq_n, be_o, wd_o);
        in_valid = 1'b1; in_is_mem = 1'b1; in_is_write = 1'b0; in_ls_variant = LS_D;
        in_result = 64'h3000; in_rd = 5'd9; in_write_to_rd = 1'b1; in_is_final = 1'b0;
        #1;
        check("hold_req", 64'(dmem_req), 64'(1));
        dmem_gnt = 1'b1;
        #1;
        check("hold_stall0", 64'(stall_out), 64'(1));
        tick();
        dmem_gnt = 1'b0;
        check("hold_wb_bubble", 64'(wb_valid_q), 64'(0));
        stall_in = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0123_4567;
        #2;
        check("hold_stall1", 64'(stall_out), 64'(1));
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            check("hold_frozen", 64'(wb_valid_q), 64'(0));
            check("hold_stall", 64'(stall_out), 64'(1));
            tick();
        end
        check("hold_frozen_last", 64'(wb_valid_q), 64'(0));
        stall_in = 1'b0;
        #2;
        check("hold_release_stall", 64'(stall_out), 64'(0));
        tick();
        in_valid = 1'b0; in_is_mem = 1'b0;
        check("hold_wb_valid", 64'(wb_valid_q), 64'(1));
        check("hold_wb_data", wb_data_q, 64'hDEAD_BEEF_0123_4567);
        check("hold_wb_rd", 64'(wb_rd_q), 64'(9));
        tick();
        check("hold_no_dup", 64'(wb_valid_q), 64'(0));

        // Reset while waiting for load data; the late rvalid must be ignored
        in_valid = 1'b1; in_is_mem = 1'b1; in_is_write = 1'b0; in_ls_variant = LS_D;
        in_result = 64'h4008; in_rd = 5'd3; in_write_to_rd = 1'b1;
        #1;
        dmem_gnt = dmem_req;
        tick();
        dmem_gnt = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_is_mem = 1'b0;
        tick();
        rst = 1'b1;
        check("rstmid_req", 64'(dmem_req), 64'(0));
        check("rstmid_wb_valid", 64'(wb_valid_q), 64'(0));
        check("rstmid_stall", 64'(stall_out), 64'(0));
        dmem_rvalid = 1'b1; dmem_rdata = 64'h5555_6666_7777_8888;
        #1;
        check("late_rvalid_stall", 64'(stall_out), 64'(0));
        tick();
        dmem_rvalid = 1'b0;
        check("late_rvalid_wb", 64'(wb_valid_q), 64'(0));
        check("late_rvalid_req", 64'(dmem_req), 64'(0));

        // Long wait crossing the timeout threshold
        do_access(1'b1, 1'b0, LS_D, 64'h5000, 64'd0, 5'd10, 1, 16, {$urandom, $urandom},
                  st_n, rq_n, be_o, wd_o);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            mem  = ($urandom_range(0, 3) != 0);
            wr   = 1'($urandom_range(0, 1));
            vi   = int'($urandom_range(0, wr ? 3 : 6));
            v    = load_store_variant_e'(3'(vi));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % 64'(size_of(v)));
            gd   = int'($urandom_range(0, 3));
            rdl  = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 3));
            if (gd > 0 && $urandom_range(0, 3) == 0) rdl = -1;
            do_access(mem, wr, v, addr, {$urandom, $urandom}, 5'($urandom), gd, rdl,
                      {$urandom, $urandom}, st_n, rq_n, be_o, wd_o);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("rand_bubble", 64'(wb_valid_q), 64'(0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
